// File: rtl/oldland_decode.sv
// oldland_decode: second pipeline stage of the Oldland core.
// Splits the fetched instruction into fields, reads the 8 x 32 register file
// (with same-cycle writeback bypass), and registers everything for execute.
// Also owns the fetch stall handshake: one branch or load/store may be in
// flight, and stall_clear tells fetch when the later stage has finished it.
module oldland_decode #(
  parameter logic [31:0] RESET_PC_PLUS_4 = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus_4,
  input  logic        flush,
  input  logic        complete,
  input  logic        wb_en,
  input  logic [2:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        stall_clear,
  output logic [31:0] pc_plus_4_q,
  output logic [1:0]  class_q,
  output logic [3:0]  opcode_q,
  output logic [2:0]  rd_q,
  output logic [31:0] ra_data_q,
  output logic [31:0] rb_data_q,
  output logic [31:0] imm_q,
  output logic        use_imm_q,
  output logic        wr_en_q,
  output logic        mem_store_q,
  output logic        protocol_err
);

  // Instruction classes as encoded in instr[31:30].
  localparam logic [1:0] CLASS_ALU    = 2'b00;
  localparam logic [1:0] CLASS_BRANCH = 2'b01;
  localparam logic [1:0] CLASS_MEM    = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t state_reg;
  state_t state_next;

  // ---------------------------------------------------------------------
  // Field extraction
  // ---------------------------------------------------------------------
  logic [1:0]  dec_class;
  logic [3:0]  dec_opcode;
  logic        dec_use_imm;
  logic [15:0] dec_imm16;
  logic [31:0] dec_imm;
  logic [2:0]  dec_rd;
  logic [2:0]  dec_ra;
  logic [2:0]  dec_rb;

  assign dec_class   = instr[31:30];
  assign dec_opcode  = instr[29:26];
  assign dec_use_imm = instr[25];
  assign dec_imm16   = instr[24:9];
  assign dec_imm     = {{16{dec_imm16[15]}}, dec_imm16};
  assign dec_rd      = instr[2:0];
  assign dec_ra      = instr[5:3];
  assign dec_rb      = instr[8:6];

  // Per-instruction control derived from class/opcode.
  logic dec_is_nop;
  logic dec_is_ctl;
  logic dec_wr_en;
  logic dec_mem_store;
  logic ctl_accept;

  // Work out whether the instruction writes rd, is a store, or needs a stall.
  always_comb begin
    dec_is_nop    = (instr == 32'h00000000);
    dec_is_ctl    = (dec_class == CLASS_BRANCH) || (dec_class == CLASS_MEM);
    dec_mem_store = (dec_class == CLASS_MEM) && dec_opcode[3];
    dec_wr_en     = 1'b0;
    case (dec_class)
      CLASS_ALU: dec_wr_en = !dec_is_nop;
      CLASS_MEM: dec_wr_en = !dec_opcode[3];
      default:   dec_wr_en = 1'b0;
    endcase
  end

  // A squashed instruction never counts as an outstanding branch/load/store.
  assign ctl_accept = dec_is_ctl && !flush;

  // ---------------------------------------------------------------------
  // Register file: 8 x 32, contents are not reset.
  // ---------------------------------------------------------------------
  logic [31:0] regs [8];

  // Writeback port.
  always_ff @(posedge clk) begin
    if (wb_en) begin
      regs[wb_reg] <= wb_data;
    end
  end

  // Two read ports (0 = ra, 1 = rb). A writeback to the same register in the
  // same cycle is forwarded so decode never sees stale data.
  logic [1:0][2:0]  rd_idx;
  logic [1:0][31:0] rd_val;

  assign rd_idx[0] = dec_ra;
  assign rd_idx[1] = dec_rb;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
      assign rd_val[gi] = (wb_en && (wb_reg == rd_idx[gi])) ? wb_data
                                                            : regs[rd_idx[gi]];
    end
  endgenerate

  logic [31:0] operand_b;
  assign operand_b = dec_use_imm ? dec_imm : rd_val[1];

  // ---------------------------------------------------------------------
  // Stall handshake FSM
  // ---------------------------------------------------------------------
  logic err_set;

  // State register; reset abandons any outstanding operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and protocol check: a second control instruction while one is
  // already outstanding is a fetch bug, flagged but still decoded.
  always_comb begin
    state_next = state_reg;
    err_set    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ctl_accept) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ctl_accept) begin
          err_set = 1'b1;
        end
        if (complete) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Completion is only meaningful while something is outstanding.
  assign stall_clear = (state_reg == ST_WAIT) && complete;

  // Sticky protocol error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      protocol_err <= 1'b0;
    end else if (err_set) begin
      protocol_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Decode -> execute pipeline register
  // ---------------------------------------------------------------------

  // Capture the decoded instruction; a flush turns it into a NOP but the
  // PC+4 still advances so execute sees a consistent program counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_plus_4_q <= RESET_PC_PLUS_4;
      class_q     <= 2'b00;
      opcode_q    <= 4'h0;
      rd_q        <= 3'd0;
      ra_data_q   <= 32'h00000000;
      rb_data_q   <= 32'h00000000;
      imm_q       <= 32'h00000000;
      use_imm_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      mem_store_q <= 1'b0;
    end else begin
      pc_plus_4_q <= pc_plus_4;
      if (flush) begin
        class_q     <= 2'b00;
        opcode_q    <= 4'h0;
        rd_q        <= 3'd0;
        ra_data_q   <= 32'h00000000;
        rb_data_q   <= 32'h00000000;
        imm_q       <= 32'h00000000;
        use_imm_q   <= 1'b0;
        wr_en_q     <= 1'b0;
        mem_store_q <= 1'b0;
      end else begin
        class_q     <= dec_class;
        opcode_q    <= dec_opcode;
        rd_q        <= dec_rd;
        ra_data_q   <= rd_val[0];
        rb_data_q   <= operand_b;
        imm_q       <= dec_imm;
        use_imm_q   <= dec_use_imm;
        wr_en_q     <= dec_wr_en;
        mem_store_q <= dec_mem_store;
      end
    end
  end

endmodule
